// File: rtl/systolic_pkg.sv
// Shared FSM state encoding and sizing helpers for the output-stationary systolic array.
package systolic_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FEED  = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Zero-injection cycles needed for the last operand pair to reach PE(ROWS-1,COLS-1).
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_os_pe.sv
// One output-stationary MAC cell: registered operand pass-through plus accumulator.
// Build option SYSTOLIC_SAT_EN: sticky saturating accumulator instead of two's-complement wrap.
module systolic_os_pe
    import systolic_pkg::*;
#(
    parameter int A_BW   = 8,
    parameter int W_BW   = 8,
    parameter int ACC_BW = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [A_BW-1:0]   a_in,
    input  logic signed [W_BW-1:0]   w_in,
    output logic signed [A_BW-1:0]   a_out,
    output logic signed [W_BW-1:0]   w_out,
    output logic signed [ACC_BW-1:0] acc
);

    localparam int P_BW = A_BW + W_BW;

    logic signed [P_BW-1:0]   prod;
    logic signed [ACC_BW-1:0] prod_ext;
    logic signed [ACC_BW-1:0] sum;
    logic signed [ACC_BW-1:0] acc_next;

    assign prod     = P_BW'(a_in) * P_BW'(w_in);
    assign prod_ext = ACC_BW'(prod);
    assign sum      = acc + prod_ext;

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    logic sat_q;
    logic ovf;

    // Overflow only when both addends share a sign and the sum flips it.
    assign ovf = (acc[ACC_BW-1] == prod_ext[ACC_BW-1]) && (sum[ACC_BW-1] != acc[ACC_BW-1]);

    always_comb begin
        acc_next = sum;
        if (sat_q) begin
            acc_next = acc;
        end else if (ovf) begin
            acc_next = acc[ACC_BW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sat_q <= 1'b0;
        end else if (en && ovf) begin
            sat_q <= 1'b1;
        end
    end
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            a_out <= '0;
            w_out <= '0;
        end else if (en) begin
            acc   <= acc_next;
            a_out <= a_in;
            w_out <= w_in;
        end
    end

endmodule

// File: rtl/systolic_os_array.sv
// Output-stationary ROWSxCOLS MAC array with input skew, K-step job sequencer and row-wise drain.
// Build option SYSTOLIC_SAT_EN selects saturating accumulators in every PE.
module systolic_os_array
    import systolic_pkg::*;
#(
    parameter int A_BW   = 8,
    parameter int W_BW   = 8,
    parameter int ACC_BW = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_MAX  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [$clog2(K_MAX+1)-1:0] i_k_len,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [A_BW*ROWS-1:0]       i_fmap,
    input  logic [W_BW*COLS-1:0]       i_weight,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [ACC_BW*COLS-1:0]     o_row_data,
    output logic [$clog2(ROWS)-1:0]    o_row_idx,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [1:0]                 o_state
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = $clog2(ROWS);
    localparam int FL = flush_len(ROWS, COLS);
    localparam int FW = $clog2(FL + 1);

    state_t          state_q;
    logic [KW-1:0]   k_len_q;
    logic [KW-1:0]   acc_cnt;
    logic [FW-1:0]   flush_cnt;
    logic [RW-1:0]   row_idx_q;
    logic            done_q;

    logic            start_acc;
    logic            hs;
    logic            advance;
    logic            clr;
    logic [KW-1:0]   k_clamped;
    logic            last_row;

    logic [A_BW*ROWS-1:0] inj_a;
    logic [W_BW*COLS-1:0] inj_w;

    logic signed [A_BW-1:0]   a_bus    [ROWS][COLS+1];
    logic signed [W_BW-1:0]   w_bus    [ROWS+1][COLS];
    logic signed [ACC_BW-1:0] acc_grid [ROWS][COLS];
    logic [ROWS-1:0]          a_edge_unused;
    logic [COLS-1:0]          w_edge_unused;

    // Handshake: a K-step vector transfers on a cycle where i_valid & o_ready; a result row
    // transfers on o_valid & i_ready. o_ready/o_valid depend on registered state only.
    assign start_acc = (state_q == ST_IDLE) && i_start;
    assign hs        = (state_q == ST_FEED) && i_valid;
    assign advance   = (state_q == ST_FEED) || (state_q == ST_FLUSH);
    assign clr       = start_acc;
    assign k_clamped = (i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : i_k_len;
    assign last_row  = (row_idx_q == RW'(ROWS - 1));

    assign inj_a = hs ? i_fmap   : '0;
    assign inj_w = hs ? i_weight : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_len_q   <= '0;
            acc_cnt   <= '0;
            flush_cnt <= '0;
            row_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        k_len_q   <= k_clamped;
                        acc_cnt   <= '0;
                        flush_cnt <= '0;
                        row_idx_q <= '0;
                        state_q   <= (k_clamped == '0) ? ST_FLUSH : ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (hs) begin
                        acc_cnt <= acc_cnt + KW'(1);
                        if (acc_cnt + KW'(1) == k_len_q) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FW'(FL - 1)) begin
                        state_q   <= ST_DRAIN;
                        row_idx_q <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (i_ready) begin
                        if (last_row) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            row_idx_q <= row_idx_q + RW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Lane r of each operand is delayed r cycles so diagonals line up inside the grid.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_bus[0][0] = inj_a[A_BW-1:0];
        end else begin : g_dly
            logic signed [A_BW-1:0] dly [1:r];
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int k = 1; k <= r; k++) dly[k] <= '0;
                end else if (advance) begin
                    dly[1] <= inj_a[(r+1)*A_BW-1 -: A_BW];
                    for (int k = 2; k <= r; k++) dly[k] <= dly[k-1];
                end
            end
            assign a_bus[r][0] = dly[r];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w_skew
        if (c == 0) begin : g_direct
            assign w_bus[0][0] = inj_w[W_BW-1:0];
        end else begin : g_dly
            logic signed [W_BW-1:0] dly [1:c];
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int k = 1; k <= c; k++) dly[k] <= '0;
                end else if (advance) begin
                    dly[1] <= inj_w[(c+1)*W_BW-1 -: W_BW];
                    for (int k = 2; k <= c; k++) dly[k] <= dly[k-1];
                end
            end
            assign w_bus[0][c] = dly[c];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            systolic_os_pe #(
                .A_BW   (A_BW),
                .W_BW   (W_BW),
                .ACC_BW (ACC_BW)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .en    (advance),
                .a_in  (a_bus[r][c]),
                .w_in  (w_bus[r][c]),
                .a_out (a_bus[r][c+1]),
                .w_out (w_bus[r+1][c]),
                .acc   (acc_grid[r][c])
            );
        end
        assign a_edge_unused[r] = ^a_bus[r][COLS];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w_edge
        assign w_edge_unused[c] = ^w_bus[ROWS][c];
    end

    always_comb begin
        o_row_data = '0;
        if (state_q == ST_DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                o_row_data[(c+1)*ACC_BW-1 -: ACC_BW] = acc_grid[row_idx_q][c];
            end
        end
    end

    assign o_ready   = (state_q == ST_FEED);
    assign o_valid   = (state_q == ST_DRAIN);
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = done_q;
    assign o_row_idx = row_idx_q;
    assign o_state   = state_q;

endmodule
